// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw push button, filters contact bounce
// with a consecutive-sample counter, and emits a clean level, one-cycle
// press/release/long-press strobes and a wrapping press counter.
module button_debouncer #(
    parameter int STABLE_CYCLES     = 16,   // consecutive equal samples to accept a change (>= 2)
    parameter int LONG_PRESS_CYCLES = 1024  // accepted-pressed cycles before long-press strobe (>= 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       stable_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [7:0] press_count
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    // Debounce counter value on which the final required sample arrives.
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // Hold counter saturation point; reaching it fires the long-press strobe.
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Two-flop synchronizer; s2 is the only view of the button used below.
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic       stable_level_q, stable_level_d;
    logic       press_pulse_q, press_pulse_d;
    logic       release_pulse_q, release_pulse_d;
    logic       long_press_pulse_q, long_press_pulse_d;
    logic [7:0] press_count_q, press_count_d;

    // Synchronizer next-state: shift the raw button through two stages.
    always_comb begin
        s1_d = button;
        s2_d = s1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Debounce FSM, hold counter and strobe generation.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        hold_cnt_d         = hold_cnt_q;
        stable_level_d     = stable_level_q;
        press_count_d      = press_count_q;
        // Strobes default low so each lasts exactly one cycle.
        press_pulse_d      = 1'b0;
        release_pulse_d    = 1'b0;
        long_press_pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // First high sample already counts toward acceptance.
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end

            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = PRESSED;
                    stable_level_d = 1'b1;
                    press_pulse_d  = 1'b1;
                    press_count_d  = press_count_q + 8'd1;
                    cnt_d          = '0;
                    hold_cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end

            RELEASE_WAIT: begin
                // A high sample here is a glitch: resume PRESSED and keep
                // the hold time accumulated so far.
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    stable_level_d  = 1'b0;
                    release_pulse_d = 1'b1;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Hold time runs while the button is accepted-pressed, including the
        // edge that completes a release; saturation limits it to one strobe.
        if ((state_q == PRESSED || state_q == RELEASE_WAIT) && (hold_cnt_q < HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q + HOLD_W'(1) == HOLD_MAX) begin
                long_press_pulse_d = 1'b1;
            end
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            hold_cnt_q         <= '0;
            stable_level_q     <= 1'b0;
            press_pulse_q      <= 1'b0;
            release_pulse_q    <= 1'b0;
            long_press_pulse_q <= 1'b0;
            press_count_q      <= 8'd0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            hold_cnt_q         <= hold_cnt_d;
            stable_level_q     <= stable_level_d;
            press_pulse_q      <= press_pulse_d;
            release_pulse_q    <= release_pulse_d;
            long_press_pulse_q <= long_press_pulse_d;
            press_count_q      <= press_count_d;
        end
    end

    // Every output comes straight from a flop.
    assign stable_level     = stable_level_q;
    assign press_pulse      = press_pulse_q;
    assign release_pulse    = release_pulse_q;
    assign long_press_pulse = long_press_pulse_q;
    assign press_count      = press_count_q;

endmodule
